tree_mem_ctrl: RTL and testbench

Controller for one `dual_port_mem` instance holding gradient-boosted tree node data. Port A is dedicated to a streaming loader that writes a tree image into a configurable address window. Port B is shared between `NUM_REQ` tree-evaluation engines through a round-robin read arbiter. The controller tracks each read through the memory's `PIPELINE+1` latency and returns the data to the requester that issued it.

---
 rtl/tree_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_tree_mem_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tree_mem_ctrl
//
// Controller for one dual-port memory that holds gradient-boosted tree node
// data.
//   * Port A belongs to a streaming loader. It writes load_len words into a
//     window that starts at load_base. Addresses wrap modulo DEPTH.
//   * Port B is shared by NUM_REQ tree-evaluation engines through a
//     round-robin read arbiter. Reads are granted only while the loader is
//     idle.
//   * Each granted read is tracked through the memory's PIPELINE+1 cycle
//     latency. The returned word is strobed to the requester that issued it.
//
// Optional feature (macro TREE_MEM_CTRL_STATS_EN):
//   When the macro is defined, two 32-bit wrapping counters are added:
//   stat_rd_grants and stat_rd_stalls. When it is undefined, neither the
//   ports nor the counters exist.
//
// Ports:
//   clk, rst                  single clock; synchronous active-high reset
//   load_start/base/len       start a load of len words at base (sampled in IDLE)
//   load_data/valid/ready     loader word stream handshake
//   load_done                 one-cycle completion pulse
//   rd_req_valid/addr/ready   per-requester read request, packed addresses,
//                             one-hot grant
//   rd_resp_valid/data        one-hot response strobe, shared response word
//   mem_ena/wea/addra/da      memory port A (write only)
//   mem_enb/web/addrb/qb      memory port B (read only; mem_web is tied low)
//   stat_rd_grants/stalls     statistics counters (TREE_MEM_CTRL_STATS_EN only)
// -----------------------------------------------------------------------------
module tree_mem_ctrl #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int PIPELINE   = 0,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic [ADDR_WIDTH-1:0]         load_base,
    input  logic [ADDR_WIDTH:0]           load_len,
    input  logic [WIDTH-1:0]              load_data,
    input  logic                          load_valid,
    output logic                          load_ready,
    output logic                          load_done,
    input  logic [NUM_REQ-1:0]            rd_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_addr,
    output logic [NUM_REQ-1:0]            rd_req_ready,
    output logic [NUM_REQ-1:0]            rd_resp_valid,
    output logic [WIDTH-1:0]              rd_resp_data,
`ifdef TREE_MEM_CTRL_STATS_EN
    output logic [31:0]                   stat_rd_grants,
    output logic [31:0]                   stat_rd_stalls,
`endif
    output logic                          mem_ena,
    output logic                          mem_wea,
    output logic [ADDR_WIDTH-1:0]         mem_addra,
    output logic [WIDTH-1:0]              mem_da,
    output logic                          mem_enb,
    output logic                          mem_web,
    output logic [ADDR_WIDTH-1:0]         mem_addrb,
    input  logic [WIDTH-1:0]              mem_qb
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ZERO = (ADDR_WIDTH + 1)'(0);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);

    logic [1:0]            state_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH:0]   remain_r;
    logic                  beat_s;

    logic [IDX_W-1:0]      last_r;
    logic [IDX_W-1:0]      cand_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic                  grant_s;

    // Response pipe: stage 0 is loaded on the grant edge, and stage PIPELINE
    // lines up with the memory's data output.
    logic [PIPELINE:0]     pipe_vld_r;
    logic [IDX_W-1:0]      pipe_idx_r [PIPELINE+1];

    // Loader handshake and port A drive. Port A is quiet unless a beat transfers.
    always_comb begin
        load_ready = (state_r == ST_LOAD);
        load_done  = (state_r == ST_DONE);
        beat_s     = load_ready & load_valid;
        mem_ena    = beat_s;
        mem_wea    = beat_s;
        if (beat_s) begin
            mem_addra = ptr_r;
            mem_da    = load_data;
        end else begin
            mem_addra = {ADDR_WIDTH{1'b0}};
            mem_da    = {WIDTH{1'b0}};
        end
    end

    // Load FSM with write pointer (wraps at DEPTH-1) and remaining-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {ADDR_WIDTH{1'b0}};
            remain_r <= REM_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        ptr_r    <= load_base;
                        remain_r <= load_len;
                        state_r  <= (load_len == REM_ZERO) ? ST_DONE : ST_LOAD;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        ptr_r    <= (ptr_r == PTR_LAST) ? {ADDR_WIDTH{1'b0}} : ptr_r + PTR_ONE;
                        remain_r <= remain_r - REM_ONE;
                        state_r  <= (remain_r == REM_ONE) ? ST_DONE : ST_LOAD;
                    end else begin
                        state_r  <= ST_LOAD;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Round-robin search. Walk NUM_REQ slots, starting one past the last
    // grant, and take the first valid requester.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        cand_s      = last_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand_s == IDX_LAST) begin
                cand_s = {IDX_W{1'b0}};
            end else begin
                cand_s = cand_s + IDX_ONE;
            end
            if (!grant_s && rd_req_valid[cand_s]) begin
                grant_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_s     = grant_s;
            end
        end
        // The loader owns the memory outside IDLE, so no read may start then.
        if (state_r != ST_IDLE) begin
            grant_s = 1'b0;
        end else begin
            grant_s = grant_s;
        end
    end

    // Grant decode and port B drive.
    always_comb begin
        rd_req_ready = {NUM_REQ{1'b0}};
        mem_enb      = grant_s;
        mem_web      = 1'b0;
        mem_addrb    = {ADDR_WIDTH{1'b0}};
        if (grant_s) begin
            rd_req_ready[grant_idx_s] = 1'b1;
            mem_addrb = rd_req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
            mem_addrb = {ADDR_WIDTH{1'b0}};
        end
    end

    // Last-grant register. The reset value NUM_REQ-1 gives requester 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= IDX_LAST;
        end else if (grant_s) begin
            last_r <= grant_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

    // Shift {valid, requester} alongside the memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r <= {(PIPELINE+1){1'b0}};
            for (int i = 0; i <= PIPELINE; i++) begin
                pipe_idx_r[i] <= {IDX_W{1'b0}};
            end
        end else begin
            pipe_vld_r[0] <= grant_s;
            pipe_idx_r[0] <= grant_idx_s;
            for (int i = 1; i <= PIPELINE; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_idx_r[i] <= pipe_idx_r[i-1];
            end
        end
    end

    // Response strobe: one-hot decode of the pipe tail.
    always_comb begin
        rd_resp_valid = {NUM_REQ{1'b0}};
        if (pipe_vld_r[PIPELINE]) begin
            rd_resp_valid[pipe_idx_r[PIPELINE]] = 1'b1;
        end else begin
            rd_resp_valid = {NUM_REQ{1'b0}};
        end
    end

    assign rd_resp_data = mem_qb;

`ifdef TREE_MEM_CTRL_STATS_EN
    // Grant and stall counters. A stall is a cycle with a pending request and no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_grants <= 32'd0;
            stat_rd_stalls <= 32'd0;
        end else begin
            if (grant_s) begin
                stat_rd_grants <= stat_rd_grants + 32'd1;
            end else begin
                stat_rd_grants <= stat_rd_grants;
            end
            if ((|rd_req_valid) && !grant_s) begin
                stat_rd_stalls <= stat_rd_stalls + 32'd1;
            end else begin
                stat_rd_stalls <= stat_rd_stalls;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tree_mem_ctrl.sv
// Self-checking bench for tree_mem_ctrl. It includes a dual-port memory
// model with PIPELINE=1 (read latency 2), a behavioural reference model
// checked every cycle, and literal expectations for the directed scenarios.
module tb_tree_mem_ctrl;
    localparam int W = 64;
    localparam int AW = 9;
    localparam int D = 512;
    localparam int P = 1;
    localparam int N = 4;
    localparam int LOG = 1024;
    localparam logic [W-1:0] INIT_BASE = 64'h1000_0000_0000_0000;

    logic clk;
    logic rst;
    logic load_start;
    logic [AW-1:0] load_base;
    logic [AW:0] load_len;
    logic [W-1:0] load_data;
    logic load_valid;
    logic load_ready;
    logic load_done;
    logic [N-1:0] rd_req_valid;
    logic [N*AW-1:0] rd_req_addr;
    logic [N-1:0] rd_req_ready;
    logic [N-1:0] rd_resp_valid;
    logic [W-1:0] rd_resp_data;
    logic mem_ena;
    logic mem_wea;
    logic [AW-1:0] mem_addra;
    logic [W-1:0] mem_da;
    logic mem_enb;
    logic mem_web;
    logic [AW-1:0] mem_addrb;
    logic [W-1:0] mem_qb;
`ifdef TREE_MEM_CTRL_STATS_EN
    logic [31:0] stat_rd_grants;
    logic [31:0] stat_rd_stalls;
    int m_gr;
    int m_st;
`endif

    tree_mem_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D), .PIPELINE(P), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
        .load_done(load_done),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
`ifdef TREE_MEM_CTRL_STATS_EN
        .stat_rd_grants(stat_rd_grants), .stat_rd_stalls(stat_rd_stalls),
`endif
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_da(mem_da),
        .mem_enb(mem_enb), .mem_web(mem_web), .mem_addrb(mem_addrb), .mem_qb(mem_qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one read register plus one output register stage.
    logic mem_init;
    logic [W-1:0] mem [D];
    logic [W-1:0] q0;
    logic [W-1:0] q1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < D; i++) mem[i] <= INIT_BASE + 64'(i);
        end else if (mem_ena && mem_wea) begin
            mem[mem_addra] <= mem_da;
        end
        if (mem_enb) q0 <= mem[mem_addrb];
        q1 <= q0;
    end
    assign mem_qb = q1;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model state.
    typedef struct {int due; int idx; logic [W-1:0] data;} resp_t;
    resp_t rq[$];
    logic [W-1:0] ref_mem [D];
    int m_phase = 0;   // 0 idle, 1 loading, 2 done pulse
    int m_addr = 0;
    int m_left = 0;
    int m_last = N - 1;
    int cyc = 0;
    bit mdl_on = 1'b0;
    int e_gnt;
    int j;
    logic beat;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_resp;
    logic [AW-1:0] e_addrb;

    // Observation logs for literal checks.
    int gnt_log [LOG];
    bit done_log [LOG];
    bit ena_log [LOG];
    bit rdy_log [LOG];
    bit any_log [LOG];
    logic [N-1:0] resp_log [LOG];
    logic [W-1:0] respd_log [LOG];

    // Compare process: check the DUT against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        if (mem_init) for (int i = 0; i < D; i++) ref_mem[i] = INIT_BASE + 64'(i);
        beat = (m_phase == 1) && load_valid;
        e_gnt = -1;
        if (m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (e_gnt < 0 && rd_req_valid[j]) e_gnt = j;
            end
        end
        e_rdy = '0;
        e_addrb = '0;
        if (e_gnt >= 0) begin
            e_rdy[e_gnt] = 1'b1;
            e_addrb = rd_req_addr[e_gnt*AW +: AW];
        end
        e_resp = '0;
        if (rq.size() > 0 && rq[0].due == cyc) e_resp[rq[0].idx] = 1'b1;

        if (mdl_on) begin
            chk("load_ready", 64'(load_ready), 64'(m_phase == 1));
            chk("load_done", 64'(load_done), 64'(m_phase == 2));
            chk("mem_ena", 64'(mem_ena), 64'(beat));
            chk("mem_wea", 64'(mem_wea), 64'(beat));
            chk("mem_addra", 64'(mem_addra), beat ? 64'(m_addr) : 64'd0);
            chk("mem_da", mem_da, beat ? load_data : 64'd0);
            chk("rd_req_ready", 64'(rd_req_ready), 64'(e_rdy));
            chk("mem_enb", 64'(mem_enb), 64'(e_gnt >= 0));
            chk("mem_addrb", 64'(mem_addrb), 64'(e_addrb));
            chk("mem_web", 64'(mem_web), 64'd0);
            chk("rd_resp_valid", 64'(rd_resp_valid), 64'(e_resp));
            if (e_resp != '0) chk("rd_resp_data", rd_resp_data, rq[0].data);
`ifdef TREE_MEM_CTRL_STATS_EN
            chk("stat_rd_grants", 64'(stat_rd_grants), 64'(m_gr));
            chk("stat_rd_stalls", 64'(stat_rd_stalls), 64'(m_st));
`endif
        end

        if (cyc < LOG) begin
            gnt_log[cyc] = -1;
            for (int i = N - 1; i >= 0; i--) if (rd_req_ready[i]) gnt_log[cyc] = i;
            done_log[cyc] = load_done;
            ena_log[cyc] = mem_ena;
            rdy_log[cyc] = load_ready;
            any_log[cyc] = |{load_ready, load_done, rd_req_ready, rd_resp_valid, mem_ena, mem_enb};
            resp_log[cyc] = rd_resp_valid;
            respd_log[cyc] = rd_resp_data;
        end

        if (e_resp != '0) void'(rq.pop_front());
        if (beat) ref_mem[m_addr] = load_data;
`ifdef TREE_MEM_CTRL_STATS_EN
        if (rst) begin
            m_gr = 0;
            m_st = 0;
        end else if (e_gnt >= 0) begin
            m_gr++;
        end else if (|rd_req_valid) begin
            m_st++;
        end
`endif
        if (rst) begin
            m_phase = 0;
            m_addr = 0;
            m_left = 0;
            m_last = N - 1;
            rq.delete();
        end else begin
            if (e_gnt >= 0) begin
                rq.push_back('{cyc + P + 1, e_gnt, ref_mem[e_addrb]});
                m_last = e_gnt;
            end
            case (m_phase)
                0: if (load_start) begin
                    m_addr = int'(load_base);
                    m_left = int'(load_len);
                    m_phase = (load_len == '0) ? 2 : 1;
                end
                1: if (beat) begin
                    m_addr = (m_addr + 1) % D;
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int t0;
    int t1;
    int cnt;

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        load_start = 1'b0; load_base = '0; load_len = '0; load_data = '0; load_valid = 1'b0;
        rd_req_valid = '0; rd_req_addr = '0;
        tick();
        mdl_on = 1'b1;
        tick(); tick();
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk); #1;
        chk("reset_outputs", 64'({load_ready, load_done, rd_req_ready, rd_resp_valid, mem_ena,
                                  mem_wea, mem_enb, mem_web, mem_addra, mem_addrb}), 64'd0);
        chk("reset_mem_da", mem_da, 64'd0);

        // Load sweep across the wrap point. A start request during LOAD must be ignored.
        tick(); load_start = 1'b1; load_base = 9'd510; load_len = 10'd4; t0 = cyc;
        tick(); load_base = 9'd0; load_len = 10'd0; load_valid = 1'b1; load_data = 64'hA0;
        tick(); load_start = 1'b0; load_data = 64'hA1;
        tick(); load_data = 64'hA2;
        tick(); load_data = 64'hA3;
        tick(); load_valid = 1'b0;
        tick(); tick();
        chk("sweep_done_at_T+5", 64'(done_log[t0+5]), 64'd1);
        chk("sweep_no_early_done", 64'(done_log[t0+4]), 64'd0);
        chk("sweep_done_one_cycle", 64'(done_log[t0+6]), 64'd0);
        chk("sweep_mem510", mem[510], 64'hA0);
        chk("sweep_mem511", mem[511], 64'hA1);
        chk("sweep_mem0", mem[0], 64'hA2);
        chk("sweep_mem1", mem[1], 64'hA3);

        // Zero-length load.
        tick(); load_start = 1'b1; load_base = 9'd7; load_len = 10'd0; t0 = cyc;
        tick(); load_start = 1'b0;
        tick(); tick(); tick();
        cnt = 0;
        for (int k = 0; k < 4; k++) cnt += int'(ena_log[t0+k]);
        chk("zero_len_done_at_T+1", 64'(done_log[t0+1]), 64'd1);
        chk("zero_len_no_done_T+2", 64'(done_log[t0+2]), 64'd0);
        chk("zero_len_no_writes", 64'(cnt), 64'd0);

        // Round-robin with all four requesters valid at addresses 1..4.
        tick(); rd_req_addr = {9'd4, 9'd3, 9'd2, 9'd1}; rd_req_valid = 4'hF; t0 = cyc;
        repeat (7) tick();
        tick(); rd_req_valid = 4'h0;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) chk("rr_grant_order", 64'(gnt_log[t0+k]), 64'(k % 4));
        chk("rr_resp0_valid", 64'(resp_log[t0+2]), 64'b0001);
        chk("rr_resp0_data", respd_log[t0+2], 64'hA3);
        chk("rr_resp1_valid", 64'(resp_log[t0+3]), 64'b0010);
        chk("rr_resp1_data", respd_log[t0+3], 64'h1000_0000_0000_0002);

        // Load/read interlock: requester 2 keeps requesting across a 3-word load.
        tick(); load_start = 1'b1; load_base = 9'd20; load_len = 10'd3;
        rd_req_addr = {9'd0, 9'd20, 9'd0, 9'd0}; rd_req_valid = 4'b0100; t0 = cyc;
        tick(); load_start = 1'b0; load_valid = 1'b1; load_data = 64'hB0;
        tick(); load_data = 64'hB1;
        tick(); load_data = 64'hB2;
        tick(); load_valid = 1'b0;
        tick(); tick();
        tick(); rd_req_valid = 4'b0000;
        repeat (4) tick();
        chk("ilk_grant_in_start_cycle", 64'(gnt_log[t0]), 64'd2);
        for (int k = 1; k <= 4; k++) chk("ilk_no_grant_during_load", 64'(gnt_log[t0+k]), 64'(-1));
        chk("ilk_done", 64'(done_log[t0+4]), 64'd1);
        chk("ilk_grant_after_done", 64'(gnt_log[t0+5]), 64'd2);
        chk("ilk_old_read_during_load", 64'(resp_log[t0+2]), 64'b0100);
        chk("ilk_old_read_data", respd_log[t0+2], 64'h1000_0000_0000_0014);
        chk("ilk_new_read_valid", 64'(resp_log[t0+7]), 64'b0100);
        chk("ilk_new_read_data", respd_log[t0+7], 64'hB0);

        // Reset after 2 of 8 beats, then start a fresh load.
        tick(); load_start = 1'b1; load_base = 9'd100; load_len = 10'd8; t0 = cyc;
        tick(); load_start = 1'b0; load_valid = 1'b1; load_data = 64'hD0;
        tick(); load_data = 64'hD1;
        tick(); load_valid = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        repeat (4) tick();
        cnt = 0;
        for (int k = 0; k < 9; k++) cnt += int'(done_log[t0+k]);
        chk("rstmid_still_loading", 64'(rdy_log[t0+3]), 64'd1);
        chk("rstmid_outputs_zero", 64'(any_log[t0+4]), 64'd0);
        chk("rstmid_no_done", 64'(cnt), 64'd0);
        chk("rstmid_mem100", mem[100], 64'hD0);
        chk("rstmid_mem102_untouched", mem[102], 64'h1000_0000_0000_0066);
        tick(); load_start = 1'b1; load_base = 9'd200; load_len = 10'd2; t1 = cyc;
        tick(); load_start = 1'b0; load_valid = 1'b1; load_data = 64'hE0;
        tick(); load_data = 64'hE1;
        tick(); load_valid = 1'b0;
        tick(); tick();
        chk("fresh_load_done", 64'(done_log[t1+3]), 64'd1);
        chk("fresh_mem200", mem[200], 64'hE0);
        chk("fresh_mem201", mem[201], 64'hE1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
